// File: rtl/run_controller_if.sv
// Control/status bundle between the run controller and the datapath it sequences.
// No storage: latency zero; no backpressure (level and pulse signals only).
interface run_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             isequal;
    logic             en_gen_data;
    logic             en_enc;
    logic             en_bus;
    logic             en_dec;
    logic             en_trans_count;
    logic             en_k_comp;
    logic             done;
    logic             busy;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] chk_count;

    modport master (
        output start, abort, isequal,
        input  en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp,
        input  done, busy, pass, err_count, chk_count
    );

    modport slave (
        input  start, abort, isequal,
        output en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp,
        output done, busy, pass, err_count, chk_count
    );
endinterface

// File: rtl/run_controller.sv
// Sequences one test run: NUM_WORDS generate cycles, a 4-stage enable chain drain, compare counting.
// All outputs registered (pass derived from registered state); no backpressure, abort ends generation early.
module run_controller #(
    parameter int NUM_WORDS = 2000,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    run_controller_if.slave rc
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             start_ok;
    logic [CNT_W-1:0] word_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (rc.start) begin
                    state_nxt = RUN;
                    start_ok  = 1'b1;
                end
            end
            RUN: begin
                if (rc.abort || (word_cnt + ONE == LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // The chain is contiguous, so the last compare cycle is the one where dec has already emptied.
                if (rc.en_k_comp && !rc.en_dec) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc.en_gen_data    <= 1'b0;
            rc.en_enc         <= 1'b0;
            rc.en_bus         <= 1'b0;
            rc.en_dec         <= 1'b0;
            rc.en_trans_count <= 1'b0;
            rc.en_k_comp      <= 1'b0;
            rc.busy           <= 1'b0;
            rc.done           <= 1'b0;
        end else begin
            rc.en_gen_data    <= (state_nxt == RUN);
            rc.en_enc         <= rc.en_gen_data;
            rc.en_bus         <= rc.en_enc;
            rc.en_dec         <= rc.en_bus;
            rc.en_trans_count <= rc.en_bus;
            rc.en_k_comp      <= rc.en_dec;
            rc.busy           <= (state_nxt == RUN) || (state_nxt == DRAIN);
            rc.done           <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt     <= '0;
            rc.chk_count <= '0;
            rc.err_count <= '0;
        end else if (start_ok) begin
            word_cnt     <= '0;
            rc.chk_count <= '0;
            rc.err_count <= '0;
        end else begin
            if (state == RUN) word_cnt <= word_cnt + ONE;
            if (rc.en_k_comp) begin
                if (rc.chk_count != '1)                rc.chk_count <= rc.chk_count + ONE;
                if (!rc.isequal && rc.err_count != '1) rc.err_count <= rc.err_count + ONE;
            end
        end
    end

    assign rc.pass = rc.done && (rc.err_count == '0);
endmodule
